// File: rtl/mpg_pkg.sv
// Shared constants for the movement pulse generator: movement bit map, axis FSM
// state encoding and per-axis request encoding.
package mpg_pkg;

  localparam logic [1:0] MV_RIGHT = 2'd3;
  localparam logic [1:0] MV_LEFT  = 2'd2;
  localparam logic [1:0] MV_DOWN  = 2'd1;
  localparam logic [1:0] MV_UP    = 2'd0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam logic [1:0] REQ_NONE = 2'd0;
  localparam logic [1:0] REQ_POS  = 2'd1;
  localparam logic [1:0] REQ_NEG  = 2'd2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_repeat.sv
// One movement axis: press/hold/auto-repeat FSM with a down-counter, producing
// registered single-cycle step strobes for the positive and negative direction.
module axis_repeat
  import mpg_pkg::*;
#(
  parameter int unsigned DELAY_CYC  = 20,
  parameter int unsigned REPEAT_CYC = 5,
  parameter int unsigned CNT_W      = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_pos,
  input  logic btn_neg,
  output logic step_pos,
  output logic step_neg,
  output logic repeating
);

  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYC - 1);

  logic [1:0]       req;
  logic [1:0]       state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pos_q, pos_d;
  logic             neg_q, neg_d;
  logic             running;

  // Opposing presses cancel each other.
  always_comb begin
    case ({btn_pos, btn_neg})
      2'b10:   req = REQ_POS;
      2'b01:   req = REQ_NEG;
      default: req = REQ_NONE;
    endcase
  end

  assign running = (state_q == ST_DELAY) || (state_q == ST_REPEAT);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    if (req == REQ_NONE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (!running || (req != dir_q)) begin
      // Fresh press, or a direct direction reversal treated as one.
      state_d = ST_DELAY;
      dir_d   = req;
      cnt_d   = DELAY_LOAD;
      pos_d   = (req == REQ_POS);
      neg_d   = (req == REQ_NEG);
    end else if (cnt_q == '0) begin
      state_d = ST_REPEAT;
      cnt_d   = REPEAT_LOAD;
      pos_d   = (dir_q == REQ_POS);
      neg_d   = (dir_q == REQ_NEG);
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dir_q   <= REQ_NONE;
      cnt_q   <= '0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
    end
  end

  assign step_pos  = pos_q;
  assign step_neg  = neg_q;
  assign repeating = (state_q == ST_REPEAT);

endmodule

// File: rtl/move_pulse_gen.sv
// Converts debounced direction-button levels into single-cycle movement strobes
// with immediate first step and hold-to-auto-repeat, one independent FSM per axis.
module move_pulse_gen
  import mpg_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned DELAY_MS  = 250,
  parameter int unsigned REPEAT_HZ = 60,
  parameter int unsigned SIMULATE  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] btn_dir,
  output logic [3:0] movement,
  output logic [1:0] repeating
);

  localparam int unsigned DELAY_CYC  = (SIMULATE != 0) ? 20 : CLK_HZ / 1000 * DELAY_MS;
  localparam int unsigned REPEAT_CYC = (SIMULATE != 0) ? 5 : CLK_HZ / REPEAT_HZ;
  localparam int unsigned CNT_W      = $clog2(max_u(DELAY_CYC, REPEAT_CYC) + 1);

  logic [3:0] btn_en;
  logic       x_pos, x_neg, x_rep;
  logic       y_pos, y_neg, y_rep;

  // Disabling looks like no buttons pressed, forcing both axes to idle.
  assign btn_en = enable ? btn_dir : 4'b0000;

  axis_repeat #(
    .DELAY_CYC (DELAY_CYC),
    .REPEAT_CYC(REPEAT_CYC),
    .CNT_W     (CNT_W)
  ) u_axis_x (
    .clk      (clk),
    .reset    (reset),
    .btn_pos  (btn_en[MV_RIGHT]),
    .btn_neg  (btn_en[MV_LEFT]),
    .step_pos (x_pos),
    .step_neg (x_neg),
    .repeating(x_rep)
  );

  axis_repeat #(
    .DELAY_CYC (DELAY_CYC),
    .REPEAT_CYC(REPEAT_CYC),
    .CNT_W     (CNT_W)
  ) u_axis_y (
    .clk      (clk),
    .reset    (reset),
    .btn_pos  (btn_en[MV_DOWN]),
    .btn_neg  (btn_en[MV_UP]),
    .step_pos (y_pos),
    .step_neg (y_neg),
    .repeating(y_rep)
  );

  always_comb begin
    movement           = 4'b0000;
    movement[MV_RIGHT] = x_pos;
    movement[MV_LEFT]  = x_neg;
    movement[MV_DOWN]  = y_pos;
    movement[MV_UP]    = y_neg;
  end

  assign repeating = {x_rep, y_rep};

endmodule

// File: tb/tb_move_pulse_gen.sv
// Bench for move_pulse_gen in SIMULATE mode: directed scenarios with fixed step
// timelines plus a randomized run, all checked against a hold-time reference model.
module tb_move_pulse_gen;

  localparam int unsigned D = 20;
  localparam int unsigned R = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] btn_dir = 4'b0000;
  logic [3:0] movement;
  logic [1:0] repeating;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  move_pulse_gen #(
    .SIMULATE(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .btn_dir  (btn_dir),
    .movement (movement),
    .repeating(repeating)
  );

  // Model: per axis, whether a press is active, its direction and how many
  // edges it has been held since the press edge.
  typedef struct packed {
    logic        act;
    logic        neg;
    logic [31:0] age;
  } ax_t;

  ax_t mx = '0;
  ax_t my = '0;

  function automatic ax_t ax_next(ax_t s, logic p, logic n);
    ax_t r = s;
    if (p == n) begin
      r.act = 1'b0;
    end else if (!s.act || (s.neg != n)) begin
      r.act = 1'b1;
      r.neg = n;
      r.age = 0;
    end else begin
      r.age = s.age + 1;
    end
    return r;
  endfunction

  function automatic logic ax_fire(ax_t s);
    return s.act && ((s.age == 0) || (s.age == D) || ((s.age > D) && ((s.age - D) % R == 0)));
  endfunction

  function automatic logic [3:0] exp_mv();
    return {ax_fire(mx) && !mx.neg, ax_fire(mx) && mx.neg,
            ax_fire(my) && !my.neg, ax_fire(my) && my.neg};
  endfunction

  function automatic logic [1:0] exp_rep();
    return {mx.act && (mx.age >= D), my.act && (my.age >= D)};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mx <= '0;
      my <= '0;
    end else begin
      mx <= ax_next(mx, enable & btn_dir[3], enable & btn_dir[2]);
      my <= ax_next(my, enable & btn_dir[1], enable & btn_dir[0]);
    end
  end

  task automatic idle();
    btn_dir = 4'b0000;
    enable  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    enable  = 1'b1;
    btn_dir = 4'b1010;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      vectors++;
      if (movement !== 4'b0000 || repeating !== 2'b00) begin
        miscompares++;
        $display("FAIL reset cyc %0d: movement=%b repeating=%b, want 0000 00", i, movement,
                 repeating);
      end
    end
    btn_dir = 4'b0000;
    reset   = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tap();
    logic [3:0] want;
    idle();
    btn_dir = 4'b1000;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      want = (i == 1) ? 4'b1000 : 4'b0000;
      vectors++;
      if (movement !== want || repeating !== 2'b00 || movement !== exp_mv()) begin
        miscompares++;
        $display("FAIL tap cyc %0d: movement=%b repeating=%b, want %b 00", i, movement,
                 repeating, want);
      end
      if (i == 3) btn_dir = 4'b0000;
    end
  endtask

  task automatic test_hold_right();
    logic [3:0] want;
    logic [1:0] want_rep;
    idle();
    btn_dir = 4'b1000;
    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      want = (i == 1 || i == 21 || i == 26 || i == 31 || i == 36) ? 4'b1000 : 4'b0000;
      want_rep = (i >= 21 && i <= 40) ? 2'b10 : 2'b00;
      vectors++;
      if (movement !== want || repeating !== want_rep || repeating !== exp_rep()) begin
        miscompares++;
        $display("FAIL hold_right cyc %0d: movement=%b repeating=%b, want %b %b", i, movement,
                 repeating, want, want_rep);
      end
      if (i == 40) btn_dir = 4'b0000;
    end
  endtask

  task automatic test_cancel();
    logic [3:0] want;
    logic [1:0] want_rep;
    idle();
    btn_dir = 4'b1101;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      want = (i == 1 || i == 21 || i == 26) ? 4'b0001 : 4'b0000;
      want_rep = (i >= 21) ? 2'b01 : 2'b00;
      vectors++;
      if (movement !== want || repeating !== want_rep || movement[3:2] !== 2'b00) begin
        miscompares++;
        $display("FAIL cancel cyc %0d: movement=%b repeating=%b, want %b %b", i, movement,
                 repeating, want, want_rep);
      end
    end
  endtask

  task automatic test_flip();
    logic [3:0] want;
    idle();
    btn_dir = 4'b1000;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      vectors++;
      if (movement !== exp_mv() || repeating !== exp_rep()) begin
        miscompares++;
        $display("FAIL flip_pre cyc %0d: movement=%b repeating=%b, want %b %b", i, movement,
                 repeating, exp_mv(), exp_rep());
      end
    end
    btn_dir = 4'b0100;
    for (int j = 1; j <= 25; j++) begin
      @(negedge clk);
      want = (j == 1 || j == 21) ? 4'b0100 : 4'b0000;
      vectors++;
      if (movement !== want || repeating[1] !== (j >= 21) || repeating !== exp_rep()) begin
        miscompares++;
        $display("FAIL flip cyc %0d: movement=%b repeating=%b, want %b x_rep=%b", j, movement,
                 repeating, want, (j >= 21));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] want;
    idle();
    btn_dir = 4'b0010;
    for (int i = 1; i <= 28; i++) begin
      @(negedge clk);
      vectors++;
      if (movement !== exp_mv() || repeating !== exp_rep()) begin
        miscompares++;
        $display("FAIL reset_mid_pre cyc %0d: movement=%b repeating=%b, want %b %b", i,
                 movement, repeating, exp_mv(), exp_rep());
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      vectors++;
      if (movement !== 4'b0000 || repeating !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_mid_hold cyc %0d: movement=%b repeating=%b, want 0000 00", i,
                 movement, repeating);
      end
    end
    reset = 1'b1;
    for (int j = 1; j <= 25; j++) begin
      @(negedge clk);
      want = (j == 1 || j == 21) ? 4'b0010 : 4'b0000;
      vectors++;
      if (movement !== want || repeating !== exp_rep()) begin
        miscompares++;
        $display("FAIL reset_mid_post cyc %0d: movement=%b repeating=%b, want %b %b", j,
                 movement, repeating, want, exp_rep());
      end
    end
  endtask

  task automatic test_enable();
    logic [3:0] want;
    idle();
    enable  = 1'b0;
    btn_dir = 4'b0001;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      vectors++;
      if (movement !== 4'b0000 || repeating !== 2'b00) begin
        miscompares++;
        $display("FAIL enable_off cyc %0d: movement=%b repeating=%b, want 0000 00", i,
                 movement, repeating);
      end
    end
    enable = 1'b1;
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk);
      want = (j == 1 || j == 21) ? 4'b0001 : 4'b0000;
      vectors++;
      if (movement !== want || movement !== exp_mv()) begin
        miscompares++;
        $display("FAIL enable_on cyc %0d: movement=%b, want %b", j, movement, want);
      end
    end
  endtask

  task automatic test_random();
    idle();
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      vectors++;
      if (movement !== exp_mv() || repeating !== exp_rep()) begin
        miscompares++;
        $display("FAIL random cyc %0d: btn=%b en=%b movement=%b repeating=%b, want %b %b", i,
                 btn_dir, enable, movement, repeating, exp_mv(), exp_rep());
      end
      if ($urandom_range(0, 29) == 0) btn_dir = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 499) == 0) reset = 1'b0;
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_tap();
    test_hold_right();
    test_cancel();
    test_flip();
    test_reset_mid();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
